lut_index_sequencer: RTL
========================

# lut_index_sequencer

Upstream stage of the address calculator in the Mithril LUT datapath. It accepts one encoded input row at a time. The row holds one X_SIZE-bit prototype code per codebook. The block then walks every output column `j` and, within each column, every codebook `i`, emitting one `(j, i, x_enc)` triple per accepted beat. The downstream address calculator registers these triples into `bram_number`/`bram_address`. Backpressure is handled by a valid/ready handshake on both sides.

## Interface
- `J_SIZE`, 9: width of column index `j`.
- `I_SIZE`, 2: width of codebook index `i`; codebook count is `2**I_SIZE`.
- `X_SIZE`, 3: width of one encoded prototype index.
- `J_COUNT`, 512: number of output columns per row; 1 ≤ J_COUNT ≤ 2**J_SIZE.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `in_codes` holds a valid row.
- `in_ready` out 1: block accepts a row this cycle.
- `in_codes` in `(2**I_SIZE)*X_SIZE`: code for codebook k is at bits `[k*X_SIZE +: X_SIZE]`.
- `out_valid` out 1: `j`/`i`/`x_enc`/flags are valid.
- `out_ready` in 1: downstream takes the beat.
- `j` out J_SIZE: column index.
- `i` out I_SIZE: codebook index.
- `x_enc` out X_SIZE: code of codebook `i` for the current row.
- `out_last_i` out 1: `i == 2**I_SIZE-1`.
- `out_last` out 1: last beat of the row (`j == J_COUNT-1` and last `i`).
- `busy` out 1: a row is being emitted.

## Operation
- States: IDLE and RUN. Reset puts the block in IDLE.
- IDLE:
  - `in_ready = 1`.
  - On `in_valid && in_ready`, latch `in_codes` into the row register, load outputs with `j=0, i=0, x_enc=code[0]`, set `out_valid=1`, and go to RUN.
- RUN: a beat is accepted when `out_valid && out_ready`. On acceptance:
  - Inner counter: `i` increments.
  - On `i` wrap to 0, `j` increments.
  - `x_enc` is reloaded with `code[next i]`.
  - After the `out_last` beat, go to IDLE with `out_valid=0`.
- Stall: while `out_valid && !out_ready`, every output is held bit-stable.
- All outputs are registered. `x_enc`, `j`, `i` and both flags always update in the same edge, so they stay aligned.
- `j` never reaches J_COUNT. J_COUNT=1 gives 2**I_SIZE beats per row.
- `busy` = (state == RUN).
- Reset values: `out_valid=0`, `j=0`, `i=0`, `x_enc=0`, `out_last_i=0`, `out_last=0`, `busy=0`, `in_ready=1`.
- Asynchronous reset mid-row discards the row and its counters with no partial flush.

## Timing
- Handshake at edge t → first beat valid after edge t+1.
- Throughput is 1 beat/cycle with `out_ready` high; a row takes J_COUNT·2**I_SIZE cycles.
- Last beat accepted at edge u → `in_ready=1` after u. The earliest next first beat is after u+2, so there is a one-cycle bubble between rows (macro off).
- `in_ready` is a decode of state/buffer registers only, with no combinational path from `in_valid` or `out_ready`.

## Configuration
- `MITHRIL_SEQ_PRELOAD_EN`: adds a one-row skid register.
- Macro defined:
  - In RUN, `in_ready = !preload_full`; the next row may be accepted any time during RUN.
  - When the `out_last` beat is accepted with the preload full, the next row's first beat is valid after the same edge, with zero bubble, and the preload moves into the row register.
  - A handshake in the same cycle as the last-beat acceptance with an empty preload bypasses directly to the row register.
- Macro undefined: no preload register; `in_ready = 0` throughout RUN.

## Structure
- Shared package `mithril_pkg`:
  - state enum `seq_state_t` (IDLE, RUN);
  - localparam function for the codes width `(2**I_SIZE)*X_SIZE`.
- One sub-module, `code_row_buffer`: holds the row register plus the optional preload slot (guarded by the macro), and exposes `code_sel(i)`.

## Test plan
Bench overrides J_COUNT=4, I_SIZE=2, X_SIZE=3.
1. Reset assert/release → all outputs 0, `in_ready=1`, `busy=0`.
2. Row `in_codes={3'd5,3'd2,3'd7,3'd1}` (k3..k0), `out_ready=1` → 16 beats:
   - beat0: j0 i0 x1;
   - beat1: j0 i1 x7;
   - beat3: j0 i3 x5, `out_last_i`;
   - beat15: j3 i3 x5, `out_last`;
   - then `out_valid=0`.
3. Same row, `out_ready` low during beats 5–7 → outputs frozen at j1 i1 x7. All 16 beats are delivered once, in order.
4. Two rows back-to-back with `in_valid` held:
   - macro off → exactly one cycle `out_valid=0` between the rows, and `in_ready=0` throughout RUN;
   - macro on → zero gap, and second-row beat0 carries `code[0]` of row 2.
5. `reset_n` low during beat 7 → outputs 0 immediately. After release, the next row starts at j0 i0 with fresh codes.
6. Macro on, third row offered while preload full → `in_ready=0` until the row-1 `out_last` beat is accepted, with no code corruption.

Source files
------------

// File: rtl/mithril_pkg.sv
// Shared types and sizing helpers for the Mithril LUT sequencing datapath.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package mithril_pkg;

  // Sequencer control state: waiting for a row, or walking a row's beats.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  // Width of one encoded input row: one X_SIZE code per codebook.
  function automatic int codes_width(input int i_size, input int x_size);
    return (2 ** i_size) * x_size;
  endfunction

endpackage

// File: rtl/code_row_buffer.sv
// Holds the active code row and, with MITHRIL_SEQ_PRELOAD_EN, a one-row preload slot.
// Latency: a row written this cycle is selectable after the next clock edge.
// Backpressure: slot_busy_o reports that no further row can be taken while a row runs.
module code_row_buffer
  import mithril_pkg::*;
#(
  parameter  int I_SIZE = 2,
  parameter  int X_SIZE = 3,
  localparam int CW     = codes_width(I_SIZE, X_SIZE)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              run_i,         // sequencer is emitting a row
  input  logic              row_done_i,    // last beat of the current row accepted
  input  logic              wr_vld_i,      // a new row is handshaked this cycle
  input  logic [CW-1:0]     wr_dat_i,
  input  logic [I_SIZE-1:0] sel_i,
  output logic [X_SIZE-1:0] code_sel_o,    // code of codebook sel_i in the active row
  output logic              start_o,       // a row enters the row register this cycle
  output logic [X_SIZE-1:0] start_code_o,  // code[0] of the row entering
  output logic              slot_busy_o    // no room for another row during RUN
);

  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] src;

`ifdef MITHRIL_SEQ_PRELOAD_EN
  logic [CW-1:0] pre_q, pre_d;
  logic          pre_full_q, pre_full_d;

  // Pick the row source and manage the preload slot: a waiting preload wins,
  // otherwise a same-cycle handshake bypasses straight into the row register.
  always_comb begin
    src        = pre_full_q ? pre_q : wr_dat_i;
    start_o    = (!run_i && wr_vld_i) || (row_done_i && (pre_full_q || wr_vld_i));
    pre_d      = pre_q;
    pre_full_d = pre_full_q;
    if (row_done_i && pre_full_q) begin
      pre_full_d = 1'b0;
    end else if (run_i && wr_vld_i && !row_done_i) begin
      pre_d      = wr_dat_i;
      pre_full_d = 1'b1;
    end
  end

  // Preload slot storage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pre_q      <= '0;
      pre_full_q <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      pre_full_q <= pre_full_d;
    end
  end

  assign slot_busy_o = pre_full_q;
`else
  // Without a preload slot a row may only land while idle or as the current row ends.
  always_comb begin
    src     = wr_dat_i;
    start_o = wr_vld_i && (!run_i || row_done_i);
  end

  assign slot_busy_o = 1'b1;
`endif

  // Row register loads whenever a new row starts.
  always_comb begin
    row_d = start_o ? src : row_q;
  end

  // Active row storage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_q <= '0;
    end else begin
      row_q <= row_d;
    end
  end

  assign code_sel_o   = row_q[int'(sel_i) * X_SIZE +: X_SIZE];
  assign start_code_o = src[X_SIZE-1:0];

endmodule

// File: rtl/lut_index_sequencer.sv
// Walks every column j and codebook i of an accepted code row, one (j, i, x_enc) beat per cycle.
// Latency: first beat valid one edge after the row handshake; fully registered outputs.
// Backpressure: outputs hold while out_ready is low; in_ready is a register decode (MITHRIL_SEQ_PRELOAD_EN adds a preload row).
module lut_index_sequencer
  import mithril_pkg::*;
#(
  parameter  int J_SIZE  = 9,
  parameter  int I_SIZE  = 2,
  parameter  int X_SIZE  = 3,
  parameter  int J_COUNT = 512,
  localparam int CW      = codes_width(I_SIZE, X_SIZE)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW-1:0]     in_codes,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [J_SIZE-1:0] j,
  output logic [I_SIZE-1:0] i,
  output logic [X_SIZE-1:0] x_enc,
  output logic              out_last_i,
  output logic              out_last,
  output logic              busy
);

  localparam logic [I_SIZE-1:0] I_LAST = '1;
  localparam logic [J_SIZE-1:0] J_LAST = J_SIZE'(J_COUNT - 1);

  seq_state_t        state_q, state_d;
  logic              vld_q, vld_d;
  logic [J_SIZE-1:0] j_q, j_d;
  logic [I_SIZE-1:0] i_q, i_d;
  logic [X_SIZE-1:0] x_q, x_d;
  logic              last_i_q, last_i_d;
  logic              last_q, last_d;

  logic              in_fire, out_fire, row_done, start;
  logic              slot_busy;
  logic [I_SIZE-1:0] i_nxt;
  logic [J_SIZE-1:0] j_nxt;
  logic [X_SIZE-1:0] code_nxt, start_code;

  assign in_ready = (state_q == IDLE) || !slot_busy;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = vld_q && out_ready;
  assign row_done = out_fire && last_q;
  assign i_nxt    = i_q + I_SIZE'(1);
  assign j_nxt    = (i_q == I_LAST) ? j_q + J_SIZE'(1) : j_q;

  code_row_buffer #(
    .I_SIZE (I_SIZE),
    .X_SIZE (X_SIZE)
  ) u_row (
    .clock        (clock),
    .reset_n      (reset_n),
    .run_i        (state_q == RUN),
    .row_done_i   (row_done),
    .wr_vld_i     (in_fire),
    .wr_dat_i     (in_codes),
    .sel_i        (i_nxt),
    .code_sel_o   (code_nxt),
    .start_o      (start),
    .start_code_o (start_code),
    .slot_busy_o  (slot_busy)
  );

  // Next-state: a starting row reloads the walk, the last beat returns to IDLE,
  // any other accepted beat steps i then j; a stall leaves everything untouched.
  always_comb begin
    state_d  = state_q;
    vld_d    = vld_q;
    j_d      = j_q;
    i_d      = i_q;
    x_d      = x_q;
    last_i_d = last_i_q;
    last_d   = last_q;
    if (start) begin
      state_d  = RUN;
      vld_d    = 1'b1;
      j_d      = '0;
      i_d      = '0;
      x_d      = start_code;
      last_i_d = (I_LAST == '0);
      last_d   = (I_LAST == '0) && (J_LAST == '0);
    end else if (row_done) begin
      state_d  = IDLE;
      vld_d    = 1'b0;
      j_d      = '0;
      i_d      = '0;
      x_d      = '0;
      last_i_d = 1'b0;
      last_d   = 1'b0;
    end else if (out_fire) begin
      j_d      = j_nxt;
      i_d      = i_nxt;
      x_d      = code_nxt;
      last_i_d = (i_nxt == I_LAST);
      last_d   = (i_nxt == I_LAST) && (j_nxt == J_LAST);
    end
  end

  // State and output registers; reset drops any row in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      vld_q    <= 1'b0;
      j_q      <= '0;
      i_q      <= '0;
      x_q      <= '0;
      last_i_q <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vld_q    <= vld_d;
      j_q      <= j_d;
      i_q      <= i_d;
      x_q      <= x_d;
      last_i_q <= last_i_d;
      last_q   <= last_d;
    end
  end

  assign out_valid  = vld_q;
  assign j          = j_q;
  assign i          = i_q;
  assign x_enc      = x_q;
  assign out_last_i = last_i_q;
  assign out_last   = last_q;
  assign busy       = (state_q == RUN);

endmodule
